// File: rtl/pc_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : pc_gen                                                     |
// | Brief    : IF-stage program counter with prioritised redirects and a   |
// |            one-entry pending-redirect buffer for stalled cycles.       |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module pc_gen #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_VEC  = 32'h0000_3000,
   parameter logic [WIDTH-1:0] EXC_VEC    = 32'h0000_4180,
   parameter int               STEP       = 4,
   parameter int               ALIGN_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             eret_req,
   input  logic [WIDTH-1:0] epc,
   input  logic             exc_req,
   output logic [WIDTH-1:0] pc,
   output logic             adel,
   output logic             redirect_pend
);

   localparam logic [WIDTH-1:0] C_STEP = WIDTH'(STEP);

   logic [WIDTH-1:0] r_pc;
   logic             r_pend_valid;
   logic [WIDTH-1:0] r_pend_addr;
   logic             w_new_req;
   logic [WIDTH-1:0] w_new_addr;

   // Exception return outranks a branch raised in the same cycle.
   assign w_new_req  = eret_req | br_valid;
   assign w_new_addr = eret_req ? epc : br_target;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc         <= RESET_VEC;
         r_pend_valid <= 1'b0;
         r_pend_addr  <= '0;
      end else if (exc_req) begin
         r_pc         <= EXC_VEC;
         r_pend_valid <= 1'b0;
      end else if (stall) begin
         // Newest request while stalled replaces any older buffered one.
         if (w_new_req) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= w_new_addr;
         end
      end else if (w_new_req) begin
         r_pc         <= w_new_addr;
         r_pend_valid <= 1'b0;
      end else if (r_pend_valid) begin
         r_pc         <= r_pend_addr;
         r_pend_valid <= 1'b0;
      end else begin
         r_pc         <= r_pc + C_STEP;
      end
   end

   assign pc            = r_pc;
   assign redirect_pend = r_pend_valid;

   generate
      if (ALIGN_BITS > 0) begin : g_align
         assign adel = |r_pc[ALIGN_BITS-1:0];
      end else begin : g_no_align
         assign adel = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-stage program counter and the next generation of the plain PC register.
- Adds a fixed redirect priority: exception vector, exception return (EPC) and branch/jump target.
- Adds a one-entry pending-redirect buffer, so a redirect that arrives while fetch is stalled is not lost.
- Adds an alignment-fault flag.
- Sits at the head of the IF stage. Its `pc` drives the instruction memory address and the IF/ID register.

Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VEC, 32'h0000_3000, PC value during and after reset.
- EXC_VEC, 32'h0000_4180, exception handler entry address.
- STEP, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low PC bits that must be zero.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC; from the hazard unit.
- br_valid  input  1  branch/jump redirect request this cycle.
- br_target  input  WIDTH  branch/jump target address.
- eret_req  input  1  exception-return redirect request.
- epc  input  WIDTH  exception-return address.
- exc_req  input  1  take exception; flushes and overrides stall.
- pc  output  WIDTH  current fetch address.
- adel  output  1  fetch address misaligned: |pc[ALIGN_BITS-1:0].
- redirect_pend  output  1  a buffered redirect is waiting.

Behaviour:
- Reset (reset==0, asynchronous, checked before clk):
  - pc=RESET_VEC, pend_valid=0, pend_addr=0.
  - Hence redirect_pend=0 and adel=0 (given an aligned RESET_VEC).
  - Holds for as long as reset is low, including mid-stall or with a redirect pending.
- State: pc register, pend_valid, pend_addr. adel and redirect_pend are combinational from state.
- Request select: new_req = eret_req | br_valid; new_addr = eret_req ? epc : br_target. eret beats branch.
- Each posedge with reset high, the first matching row applies:
  1. exc_req=1: pc<=EXC_VEC; pend_valid<=0. Applies regardless of stall and discards any pending or new request.
  2. stall=1 and new_req=1: pc holds; pend_valid<=1; pend_addr<=new_addr. Overwrites an older pending entry; newest wins.
  3. stall=1 and new_req=0: pc holds; pending unchanged.
  4. stall=0 and new_req=1: pc<=new_addr; pend_valid<=0. A live request supersedes the stale pending one.
  5. stall=0 and pend_valid=1: pc<=pend_addr; pend_valid<=0.
  6. Otherwise: pc<=pc+STEP, modulo 2^WIDTH (all-ones-region wraps to low addresses; no carry out).
- Latency:
  - A redirect issued in a non-stalled cycle appears on pc after exactly one posedge.
  - A redirect issued while stalled appears one posedge after the first cycle with stall=0.
- Targets are loaded unmodified even when misaligned; adel rises the cycle pc holds the bad value. Faulting is downstream's job.
- No X propagation: the inputs select nothing when all request/stall lines are 0.

Test Plan:
1. Reset then free-run: reset low 3 cycles -> pc=0x3000. Release, 4 posedges -> pc=0x3004, 0x3008, 0x300C, 0x3010; adel=0, redirect_pend=0 throughout.
2. Branch unstalled: at pc=0x3008 assert br_valid, br_target=0x3100 for one cycle -> next pc=0x3100, then 0x3104.
3. Branch during stall: stall=1 for 3 cycles at pc=0x3010, with br_valid/br_target=0x3200 pulsed in cycle 1:
   - pc stays 0x3010; redirect_pend=1 from the next cycle.
   - After stall drops -> pc=0x3200, redirect_pend=0.
   - Repeat with a second branch to 0x3300 in stall cycle 2 -> pc=0x3300 (overwrite).
4. Priority: same cycle, exc_req=1, eret_req=1 epc=0x3050, br_valid=1, stall=1, with a pending entry present -> pc=0x4180, redirect_pend=0. Next cycle eret_req alone (stall=0) -> pc=0x3050.
5. Misalignment and wrap:
   - br_target=0x3102 -> pc=0x3102 and adel=1; next pc=0x3106, adel=1.
   - Separately, a branch to 0xFFFF_FFFC then one free cycle -> pc=0x0000_0000.
6. Async reset mid-operation: with redirect_pend=1 and stall=1, drop reset between clock edges -> pc=0x3000 and redirect_pend=0 immediately, without waiting for clk. After release, pc resumes 0x3004 and the stale target is never loaded.
